aes_encipher_block: RTL
=======================

// Module: aes_encipher_block
// PURPOSE
//  Iterative AES encipher datapath, the forward-direction counterpart of the decipher block.
//  Runs the initial, main and final rounds for AES-128 and AES-256.
//  Uses one shared 32-bit aes_sbox instance, one word per cycle.
//  Round keys come from the external key memory, indexed by the round output.
//  Sits beside the decipher block under aes_core; the core muxes new_block and ready by mode.
// PARAMETERS
//  none - widths fixed; localparams AES128_ROUNDS=4'ha, AES256_ROUNDS=4'he
// PORTS
//  clk        in   1    clock, all state updates on rising edge
//  reset      in   1    synchronous, active-high reset
//  next       in   1    start encipher of block; sampled only in IDLE
//  keylen     in   1    0=AES-128 (10 rounds), 1=AES-256 (14 rounds); held stable while busy
//  round      out  4    current round index, selects round_key in key memory
//  round_key  in   128  round key for index round; combinationally valid same cycle
//  block      in   128  plaintext; sampled in INIT state only
//  new_block  out  128  state register {w0,w1,w2,w3}; ciphertext when ready rises
//  ready      out  1    1=idle/result valid, 0=busy
//  sboxw      out  32   word to shared aes_sbox
//  new_sboxw  in   32   substituted word from aes_sbox (combinational)
// BEHAVIOUR
//  Reset (synchronous, active high, wins over all else):
//   - w0..w3=0, round=0, sword_ctr=0, ready=1, FSM=IDLE; sboxw=0 whenever not in SBOX.
//  FSM states: IDLE, INIT, SBOX, MAIN (2-bit).
//  IDLE:
//   - next=1: round<=0, ready<=0 -> INIT.
//   - next=0: hold all state; new_block keeps the last result.
//  INIT:
//   - state <= block ^ round_key (rk0); round<=1; sword_ctr<=0 -> SBOX.
//  SBOX (4 cycles):
//   - sboxw = word[sword_ctr]; only that word is written with new_sboxw; sword_ctr++.
//   - On sword_ctr==3: -> MAIN (counter wraps to 0).
//  MAIN, round < Nr:
//   - state <= mixcolumns(shiftrows(state)) ^ round_key; round++; sword_ctr<=0 -> SBOX.
//  MAIN, round == Nr (final):
//   - state <= shiftrows(state) ^ round_key; ready<=1 -> IDLE; round holds Nr.
//  Round functions:
//   - shiftrows: row r of each column rotated left by r; word w_c byte r is taken from w_((c+r) mod 4).
//   - mixcolumns: per word, standard {02,03,01,01} circulant over GF(2^8), poly 0x11b (xtime).
//  Latency, counted in rising edges from the edge sampling next=1:
//   - ready=1 after 52 edges for AES-128 (1+1+10*5).
//   - ready=1 after 72 edges for AES-256 (1+1+14*5).
//  next while busy: ignored; no restart, no queueing.
//  keylen change while busy: undefined result; the core guarantees it is stable.
//  next in the same cycle ready rises (final MAIN): ignored; FSM is not yet IDLE.
//  reset mid-operation: next cycle is IDLE with ready=1, new_block=0; a following next starts clean.
//  Unused FSM encodings: none exist (4 states, 2 bits); default branch -> IDLE.
// TESTING
//  1. Reset defaults: assert reset 3 cycles -> ready=1, round=0, new_block=0.
//  2. AES-128 (FIPS-197 C.1): key 000102..0f, pt 00112233445566778899aabbccddeeff.
//     -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, ready high exactly 52 edges after next.
//  3. AES-256 (FIPS-197 C.3): key 000102..1f, same pt.
//     -> ct 8ea2b7ca516745bfeafc49904b496089, ready high after 72 edges.
//  4. Round sequencing: log round while busy.
//     -> 0 in INIT; 1..Nr each held 5 cycles; holds Nr after completion.
//  5. next pulsed at cycle 20 of a busy run -> result and latency identical to test 2.
//  6. reset at cycle 30 mid-run, then new next -> ready=1 and new_block=0 one cycle after reset;
//     rerun of test 2 produces correct ct.

Source files
------------

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher datapath: one shared S-box word per cycle,
// round keys fetched from external key memory at index `round`.
module aes_encipher_block (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic [1:0]   fsm_state
);

  localparam logic [3:0] AES128_ROUNDS = 4'ha;
  localparam logic [3:0] AES256_ROUNDS = 4'he;

  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_INIT = 2'd1;
  localparam logic [1:0] CTRL_SBOX = 2'd2;
  localparam logic [1:0] CTRL_MAIN = 2'd3;

  // Handshake: next is taken only while ready=1 (IDLE); ready drops the cycle
  // after, and rises again with new_block holding the ciphertext until the next start.

  logic [1:0]   state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         ready_q, ready_d;
  logic [3:0]   num_rounds;
  logic [6:0]   word_sel;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  // Byte i of the state sits at [127-8i -: 8]; column c row r is byte 4c+r.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  assign num_rounds = keylen ? AES256_ROUNDS : AES128_ROUNDS;
  assign word_sel   = {~sword_ctr_q, 5'b0_0000};

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    round_d     = round_q;
    sword_ctr_d = sword_ctr_q;
    ready_d     = ready_q;
    sboxw       = 32'h0;

    case (state_q)
      CTRL_IDLE: begin
        if (next) begin
          round_d = 4'h0;
          ready_d = 1'b0;
          state_d = CTRL_INIT;
        end
      end

      CTRL_INIT: begin
        blk_d       = block ^ round_key;
        round_d     = 4'h1;
        sword_ctr_d = 2'd0;
        state_d     = CTRL_SBOX;
      end

      CTRL_SBOX: begin
        sboxw                = blk_q[word_sel +: 32];
        blk_d[word_sel +: 32] = new_sboxw;
        sword_ctr_d          = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) begin
          state_d = CTRL_MAIN;
        end
      end

      CTRL_MAIN: begin
        if (round_q == num_rounds) begin
          blk_d   = shiftrows(blk_q) ^ round_key;
          ready_d = 1'b1;
          state_d = CTRL_IDLE;
        end else begin
          blk_d       = mixcolumns(shiftrows(blk_q)) ^ round_key;
          round_d     = round_q + 4'h1;
          sword_ctr_d = 2'd0;
          state_d     = CTRL_SBOX;
        end
      end

      default: begin
        state_d = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CTRL_IDLE;
      blk_q       <= 128'h0;
      round_q     <= 4'h0;
      sword_ctr_q <= 2'd0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      round_q     <= round_d;
      sword_ctr_q <= sword_ctr_d;
      ready_q     <= ready_d;
    end
  end

  assign round     = round_q;
  assign new_block = blk_q;
  assign ready     = ready_q;
  assign fsm_state = state_q;

endmodule
